// File: rtl/des_job_arbiter_if.sv
// Requester-side channel of the DES job arbiter: job request and result response.
// Ports: req_valid/req_ed_sel/req_data/req_ack (job in), resp_valid/resp_ready/resp_data/resp_err (result out).
interface des_job_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ed_sel;
    logic [64*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ack;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [NUM_REQ-1:0]    resp_ready;
    logic [63:0]           resp_data;
    logic                  resp_err;

    // requesters drive jobs and accept results
    modport master (
        output req_valid, req_ed_sel, req_data, resp_ready,
        input  req_ack, resp_valid, resp_data, resp_err
    );

    // the arbiter accepts jobs and returns results
    modport slave (
        input  req_valid, req_ed_sel, req_data, resp_ready,
        output req_ack, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/des_job_arbiter.sv
// Round-robin scheduler sharing one DES core among NUM_REQ requesters, one job in flight.
// Ports: clk, rst (async active-high), bus (slave side of des_job_arbiter_if),
//   core_data_in/core_ready/core_ed_sel (launch), core_data_out/core_done (result),
//   busy, grant_id. Optional macro DES_ARB_TIMEOUT_EN aborts jobs after TIMEOUT_CYC.
module des_job_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int ID_W        = 1,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic            clk,
    input  logic            rst,
    des_job_arbiter_if.slave bus,
    output logic [63:0]     core_data_in,
    output logic            core_ready,
    output logic            core_ed_sel,
    input  logic [63:0]     core_data_out,
    input  logic            core_done,
    output logic            busy,
    output logic [ID_W-1:0] grant_id
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W != $clog2(NUM_REQ) || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("des_job_arbiter: invalid parameter set");
    end

    typedef enum logic [1:0] {IDLE, LOAD, BUSY, RESP} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    gid_q, gid_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] rv_q, rv_d;
    logic               cr_q, cr_d;
    logic [63:0]        cdi_q, cdi_d;
    logic               ced_q, ced_d;
    logic [63:0]        rd_q, rd_d;
    logic               busy_q, busy_d;

    logic               found;
    logic [ID_W-1:0]    win;

`ifdef DES_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
`endif

    // Two passes give the wrap-around search: indices at or above the
    // pointer first, then the ones below it.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && bus.req_valid[j] && ID_W'(j) >= rr_q) begin
                found = 1'b1;
                win   = ID_W'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && bus.req_valid[j] && ID_W'(j) < rr_q) begin
                found = 1'b1;
                win   = ID_W'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gid_d   = gid_q;
        ack_d   = '0;
        rv_d    = rv_q;
        cr_d    = 1'b0;
        cdi_d   = cdi_q;
        ced_d   = ced_q;
        rd_d    = rd_q;
`ifdef DES_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (1'b1)
            (state_q == IDLE): begin
                if (found) begin
                    state_d = LOAD;
                    gid_d   = win;
                    rr_d    = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                    for (int j = 0; j < NUM_REQ; j++) begin
                        if (ID_W'(j) == win) begin
                            ack_d[j] = 1'b1;
                            cdi_d    = bus.req_data[64*j +: 64];
                            ced_d    = bus.req_ed_sel[j];
                        end
                    end
                end
            end
            (state_q == LOAD): begin
                cr_d    = 1'b1;
                state_d = BUSY;
`ifdef DES_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            (state_q == BUSY): begin
                if (core_done) begin
                    state_d = RESP;
                    rd_d    = core_data_out;
                    for (int j = 0; j < NUM_REQ; j++) begin
                        if (ID_W'(j) == gid_q) rv_d[j] = 1'b1;
                    end
                end
`ifdef DES_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
                    state_d = RESP;
                    rd_d    = '0;
                    err_d   = 1'b1;
                    for (int j = 0; j < NUM_REQ; j++) begin
                        if (ID_W'(j) == gid_q) rv_d[j] = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            (state_q == RESP): begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (ID_W'(j) == gid_q && bus.resp_ready[j]) begin
                        state_d = IDLE;
                        rv_d    = '0;
`ifdef DES_ARB_TIMEOUT_EN
                        err_d   = 1'b0;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gid_q   <= '0;
            ack_q   <= '0;
            rv_q    <= '0;
            cr_q    <= 1'b0;
            cdi_q   <= '0;
            ced_q   <= 1'b0;
            rd_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gid_q   <= gid_d;
            ack_q   <= ack_d;
            rv_q    <= rv_d;
            cr_q    <= cr_d;
            cdi_q   <= cdi_d;
            ced_q   <= ced_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
        end
    end

`ifdef DES_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign bus.resp_err = err_q;
`else
    assign bus.resp_err = 1'b0;
`endif

    assign bus.req_ack    = ack_q;
    assign bus.resp_valid = rv_q;
    assign bus.resp_data  = rd_q;
    assign core_data_in   = cdi_q;
    assign core_ready     = cr_q;
    assign core_ed_sel    = ced_q;
    assign busy           = busy_q;
    assign grant_id       = gid_q;

endmodule

// File: tb/tb_des_job_arbiter.sv
// Directed bench for des_job_arbiter (NUM_REQ=2, TIMEOUT_CYC=8).
// Drives jobs and core_done by hand; every expectation is a hand-computed constant.
module tb_des_job_arbiter;

    logic        clk;
    logic        rst;
    logic [63:0] core_data_in;
    logic        core_ready;
    logic        core_ed_sel;
    logic [63:0] core_data_out;
    logic        core_done;
    logic        busy;
    logic [0:0]  grant_id;

    int total;
    int bad;

    des_job_arbiter_if #(.NUM_REQ(2)) bus ();

    des_job_arbiter #(
        .NUM_REQ    (2),
        .ID_W       (1),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .core_data_in (core_data_in),
        .core_ready   (core_ready),
        .core_ed_sel  (core_ed_sel),
        .core_data_out(core_data_out),
        .core_done    (core_done),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Runs one job to completion. Caller has DUT in IDLE and req_valid set
    // so the next edge arbitrates. pend is req_valid after the ack, post is
    // req_valid after the response completes, hold is cycles of back-pressure.
    task automatic do_job(input string tag, input int id, input logic ed,
                          input logic [63:0] din, input logic [63:0] dout,
                          input int dly, input int hold,
                          input logic [1:0] pend, input logic [1:0] post);
        logic [1:0] oh;
        oh = 2'(1 << id);
        tick();
        chk({tag, ".ack"}, 64'(bus.req_ack), 64'(oh));
        chk({tag, ".gid"}, 64'(grant_id), 64'(id));
        chk({tag, ".busy"}, 64'(busy), 64'd1);
        chk({tag, ".cdi"}, core_data_in, din);
        chk({tag, ".ced"}, 64'(core_ed_sel), 64'(ed));
        bus.req_valid = pend;
        tick();
        chk({tag, ".cready"}, 64'(core_ready), 64'd1);
        chk({tag, ".ack_off"}, 64'(bus.req_ack), 64'd0);
        for (int i = 1; i < dly; i++) begin
            tick();
            if (i == 1) chk({tag, ".cready_pulse"}, 64'(core_ready), 64'd0);
            chk({tag, ".no_early_resp"}, 64'(bus.resp_valid), 64'd0);
        end
        core_data_out = dout;
        core_done     = 1'b1;
        tick();
        core_done     = 1'b0;
        core_data_out = 64'hFFFF_0000_FFFF_0000;
        chk({tag, ".rvalid"}, 64'(bus.resp_valid), 64'(oh));
        chk({tag, ".rdata"}, bus.resp_data, dout);
        chk({tag, ".rerr"}, 64'(bus.resp_err), 64'd0);
        bus.resp_ready = ~oh;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({tag, ".hold_rvalid"}, 64'(bus.resp_valid), 64'(oh));
            chk({tag, ".hold_rdata"}, bus.resp_data, dout);
            chk({tag, ".hold_cready"}, 64'(core_ready), 64'd0);
            chk({tag, ".hold_ack"}, 64'(bus.req_ack), 64'd0);
        end
        bus.resp_ready = oh;
        tick();
        chk({tag, ".rvalid_clr"}, 64'(bus.resp_valid), 64'd0);
        chk({tag, ".idle"}, 64'(busy), 64'd0);
        bus.resp_ready = 2'b00;
        bus.req_valid  = post;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b0;
        core_data_out  = '0;
        core_done      = 1'b0;
        bus.req_valid  = '0;
        bus.req_ed_sel = '0;
        bus.req_data   = '0;
        bus.resp_ready = '0;

        #2 rst = 1'b1;
        #1;
        chk("rst.ack", 64'(bus.req_ack), 64'd0);
        chk("rst.rvalid", 64'(bus.resp_valid), 64'd0);
        chk("rst.cready", 64'(core_ready), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.gid", 64'(grant_id), 64'd0);
        chk("rst.cdi", core_data_in, 64'd0);
        chk("rst.rdata", bus.resp_data, 64'd0);
        chk("rst.err", 64'(bus.resp_err), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // single job on requester 0
        bus.req_data[63:0] = 64'h0123456789ABCDEF;
        bus.req_ed_sel     = 2'b00;
        bus.req_valid      = 2'b01;
        do_job("single", 0, 1'b0, 64'h0123456789ABCDEF, 64'h85E813540F0AB405,
               5, 0, 2'b00, 2'b00);

        // restart rr pointer at 0 for contention
        rst = 1'b1;
        #1;
        rst = 1'b0;
        tick();

        bus.req_data   = {64'hA5A5_5A5A_0F0F_F0F0, 64'h1357_9BDF_2468_ACE0};
        bus.req_ed_sel = 2'b10;
        bus.req_valid  = 2'b11;
        do_job("cont0", 0, 1'b0, 64'h1357_9BDF_2468_ACE0, 64'h1111_2222_3333_4444, 3, 0, 2'b10, 2'b11);
        do_job("cont1", 1, 1'b1, 64'hA5A5_5A5A_0F0F_F0F0, 64'h5555_6666_7777_8888, 4, 0, 2'b01, 2'b11);
        do_job("cont2", 0, 1'b0, 64'h1357_9BDF_2468_ACE0, 64'h9999_AAAA_BBBB_CCCC, 2, 0, 2'b10, 2'b11);
        do_job("cont3", 1, 1'b1, 64'hA5A5_5A5A_0F0F_F0F0, 64'hDDDD_EEEE_0000_1234, 6, 0, 2'b01, 2'b00);

        // back-pressure on requester 1 with requester 0 pending meanwhile
        bus.req_valid = 2'b10;
        do_job("bp", 1, 1'b1, 64'hA5A5_5A5A_0F0F_F0F0, 64'hCAFE_F00D_DEAD_BEEF, 5, 10, 2'b01, 2'b00);

        // reset three cycles after core_ready
        bus.req_valid = 2'b01;
        tick();
        chk("rstbusy.ack", 64'(bus.req_ack), 64'd1);
        bus.req_valid = 2'b00;
        tick();
        chk("rstbusy.cready", 64'(core_ready), 64'd1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rstbusy.busy", 64'(busy), 64'd0);
        chk("rstbusy.cdi", core_data_in, 64'd0);
        chk("rstbusy.rdata", bus.resp_data, 64'd0);
        chk("rstbusy.cready0", 64'(core_ready), 64'd0);
        chk("rstbusy.rvalid", 64'(bus.resp_valid), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        core_data_out = 64'h0BAD_0BAD_0BAD_0BAD;
        core_done     = 1'b1;
        tick();
        core_done     = 1'b0;
        chk("rstbusy.late_done", 64'(bus.resp_valid), 64'd0);
        chk("rstbusy.idle", 64'(busy), 64'd0);

        // spurious core_done while idle
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("spur.rvalid", 64'(bus.resp_valid), 64'd0);
        chk("spur.busy", 64'(busy), 64'd0);
        tick();
        chk("spur.busy2", 64'(busy), 64'd0);
        chk("spur.cready", 64'(core_ready), 64'd0);

        // recovery after reset: lone requester 1, rr pointer back at 0
        bus.req_valid = 2'b10;
        do_job("recover", 1, 1'b1, 64'hA5A5_5A5A_0F0F_F0F0, 64'h0F1E_2D3C_4B5A_6978, 3, 0, 2'b00, 2'b00);

`ifdef DES_ARB_TIMEOUT_EN
        bus.req_valid = 2'b01;
        tick();
        chk("to.ack", 64'(bus.req_ack), 64'd1);
        bus.req_valid = 2'b00;
        tick();
        chk("to.cready", 64'(core_ready), 64'd1);
        repeat (8) tick();
        chk("to.not_yet", 64'(bus.resp_valid), 64'd0);
        tick();
        chk("to.rvalid", 64'(bus.resp_valid), 64'd1);
        chk("to.err", 64'(bus.resp_err), 64'd1);
        chk("to.rdata", bus.resp_data, 64'd0);
        bus.resp_ready = 2'b01;
        tick();
        bus.resp_ready = 2'b00;
        chk("to.rvalid_clr", 64'(bus.resp_valid), 64'd0);
        chk("to.err_clr", 64'(bus.resp_err), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
